// File: rtl/progress_watchdog_pkg.sv
// progress_watchdog_pkg
//   Shared types and helpers for the multi-channel progress watchdog.
//   - chan_state_e    : per-channel state (IDLE, WAIT, EXPIRED)
//   - stall_cnt_width : width of a stall counter able to hold 0..period
//   - id_width        : width of a channel index (minimum 1 bit)
package progress_watchdog_pkg;

  typedef enum logic [1:0] {
    CH_IDLE    = 2'd0,
    CH_WAIT    = 2'd1,
    CH_EXPIRED = 2'd2
  } chan_state_e;

  function automatic int stall_cnt_width(input int period);
    return (period < 1) ? 1 : $clog2(period + 1);
  endfunction

  function automatic int id_width(input int num_chans);
    return (num_chans > 1) ? $clog2(num_chans) : 1;
  endfunction

endpackage

// File: rtl/progress_watchdog_chan.sv
// progress_watchdog_chan
//   One monitored channel: a three-state FSM plus a stall counter that
//   counts consecutive enabled edges with work outstanding and no progress.
//   Ports:
//     clk, reset_n      : clock, asynchronous active-low reset
//     en                : count enable (state holds when low)
//     clear             : synchronous clear back to IDLE
//     chan_active       : channel has outstanding work
//     chan_progress     : a handshake fired this cycle (ignored when idle)
//     state             : registered FSM state, also used as debug view
//     expiring          : this enabled edge moves the channel into EXPIRED
module progress_watchdog_chan
  import progress_watchdog_pkg::*;
#(
  parameter int p_timeout_period = 10000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        clear,
  input  logic        chan_active,
  input  logic        chan_progress,
  output chan_state_e state,
  output logic        expiring
);

  localparam int CNT_W = stall_cnt_width(p_timeout_period);
  localparam logic [CNT_W-1:0] PERIOD = CNT_W'(p_timeout_period);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_nxt;
  chan_state_e      state_nxt;

  // cnt never exceeds PERIOD-1 outside EXPIRED, so the increment cannot wrap.
  assign cnt_inc = cnt + 1'b1;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      CH_IDLE: begin
        if (chan_active && !chan_progress) begin
          cnt_nxt   = cnt_inc;
          // A period of 1 expires on the very first stalled edge.
          state_nxt = (cnt_inc == PERIOD) ? CH_EXPIRED : CH_WAIT;
        end
      end
      CH_WAIT: begin
        if (!chan_active) begin
          state_nxt = CH_IDLE;
          cnt_nxt   = '0;
        end else if (chan_progress) begin
          // Progress wins even on the edge that would have expired.
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == PERIOD) state_nxt = CH_EXPIRED;
        end
      end
      default: begin
        // EXPIRED: frozen until clear or reset.
      end
    endcase
  end

  assign expiring = en && !clear && (state != CH_EXPIRED) && (state_nxt == CH_EXPIRED);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= CH_IDLE;
      cnt   <= '0;
    end else if (clear) begin
      state <= CH_IDLE;
      cnt   <= '0;
    end else if (en) begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: rtl/progress_watchdog.sv
// progress_watchdog
//   Per-channel stall detector with sticky timeout flags, first-timeout
//   capture and a free-running saturating cycle counter.
//   Channel semantics: chan_active[i] means channel i has outstanding work;
//   chan_progress[i] means a handshake completed on that cycle and only
//   counts while chan_active[i] is high.
//   Optional build macro: PROGRESS_WATCHDOG_TRACE_EN prints a red
//   "TIMEOUT ch<i> @ <time>ns" line whenever a channel expires; outputs
//   are identical with or without it.
//   Ports:
//     clk, reset_n       : clock, asynchronous active-low reset
//     en                 : count enable; all state holds when low
//     clear              : synchronous clear of counters, states and flags
//     chan_active        : per-channel outstanding-work indication
//     chan_progress      : per-channel handshake-this-cycle indication
//     timeout_chan       : sticky per-channel timeout flags
//     timeout_occurred   : OR of timeout_chan
//     first_timeout_vld  : first_timeout_id is valid (sticky)
//     first_timeout_id   : lowest index among the first channels to expire
//     cycles             : enabled edges since reset/clear, saturating
module progress_watchdog
  import progress_watchdog_pkg::*;
#(
  parameter int p_num_chans      = 4,
  parameter int p_timeout_period = 10000,
  parameter int p_cnt_width      = 32
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               en,
  input  logic                               clear,
  input  logic [p_num_chans-1:0]             chan_active,
  input  logic [p_num_chans-1:0]             chan_progress,
  output logic [p_num_chans-1:0]             timeout_chan,
  output logic                               timeout_occurred,
  output logic                               first_timeout_vld,
  output logic [id_width(p_num_chans)-1:0]   first_timeout_id,
  output logic [p_cnt_width-1:0]             cycles
);

  localparam int ID_W = id_width(p_num_chans);

  chan_state_e            chan_state [p_num_chans];
  logic [p_num_chans-1:0] chan_expiring;
  logic [ID_W-1:0]        first_idx;

  for (genvar g = 0; g < p_num_chans; g++) begin : g_chan
    progress_watchdog_chan #(
      .p_timeout_period(p_timeout_period)
    ) u_chan (
      .clk          (clk),
      .reset_n      (reset_n),
      .en           (en),
      .clear        (clear),
      .chan_active  (chan_active[g]),
      .chan_progress(chan_progress[g]),
      .state        (chan_state[g]),
      .expiring     (chan_expiring[g])
    );

    assign timeout_chan[g] = (chan_state[g] == CH_EXPIRED);

`ifdef PROGRESS_WATCHDOG_TRACE_EN
    always @(posedge clk) begin
      if (reset_n && chan_expiring[g])
        $display("%c[31mTIMEOUT ch%0d @ %0tns%c[0m", 8'd27, g, $time, 8'd27);
    end
`else
`endif
  end

  assign timeout_occurred = |timeout_chan;

  // Lowest-index channel expiring on this edge; scanned high to low so the
  // last assignment is the lowest index.
  always_comb begin
    first_idx = '0;
    for (int i = p_num_chans - 1; i >= 0; i--) begin
      if (chan_expiring[i]) first_idx = ID_W'(i);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      first_timeout_vld <= 1'b0;
      first_timeout_id  <= '0;
    end else if (clear) begin
      first_timeout_vld <= 1'b0;
      first_timeout_id  <= '0;
    end else if (en && !first_timeout_vld && (|chan_expiring)) begin
      first_timeout_vld <= 1'b1;
      first_timeout_id  <= first_idx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycles <= '0;
    end else if (clear) begin
      cycles <= '0;
    end else if (en && (cycles != '1)) begin
      cycles <= cycles + 1'b1;
    end
  end

endmodule
